// File: rtl/s_mem_arbiter_pkg.sv
// Shared types and sizes for the RC4 S-memory arbiter.
// Requester indices are fixed: 0 = initializer, 1 = KSA swapper, 2 = PRGA decrypter.
package s_mem_pkg;

    localparam int N_REQ  = 3;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam int REQ_INIT = 0;
    localparam int REQ_KSA  = 1;
    localparam int REQ_PRGA = 2;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0] req_idx_t;

    // One slot of the read-return pipeline: which requester the data belongs to.
    typedef struct packed {
        logic     valid;
        req_idx_t idx;
    } rd_tag_t;

    function automatic req_idx_t next_idx(input req_idx_t idx);
        return (idx == req_idx_t'(N_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    function automatic req_vec_t idx_to_onehot(input req_idx_t idx);
        return req_vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/s_mem_arbiter_if.sv
// Requester-side bus of the S-memory arbiter: flattened per-requester strobes plus
// the grant and the broadcast read-return channel.
interface s_mem_arbiter_if;
    import s_mem_pkg::*;

    req_vec_t                  req;
    logic [N_REQ*ADDR_W-1:0]   req_addr;
    logic [N_REQ*DATA_W-1:0]   req_wdata;
    req_vec_t                  req_wren;
    req_vec_t                  req_rden;
    req_vec_t                  gnt;
    logic [DATA_W-1:0]         rdata;
    req_vec_t                  rvalid;

    modport master (
        output req, req_addr, req_wdata, req_wren, req_rden,
        input  gnt, rdata, rvalid
    );

    modport slave (
        input  req, req_addr, req_wdata, req_wren, req_rden,
        output gnt, rdata, rvalid
    );

endinterface

// File: rtl/s_mem_arbiter_rr_pick.sv
// Circular priority pick: first set request at or after ptr_i, wrapping at N_REQ.
module s_mem_arbiter_rr_pick
    import s_mem_pkg::*;
(
    input  req_vec_t req_i,
    input  req_idx_t ptr_i,
    output logic     any_o,
    output req_vec_t onehot_o,
    output req_idx_t idx_o
);

    int unsigned cand;

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop
        // leaves a value unassigned and infers a latch.
        any_o = 1'b0;
        idx_o = '0;
        cand  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = req_idx_t'(cand);
            end
        end
        onehot_o = any_o ? idx_to_onehot(idx_o) : '0;
    end

endmodule

// File: rtl/s_mem_arbiter.sv
// Single-port S-memory arbiter: burst-locked round-robin grant, owner mux onto the
// RAM, and a tag pipeline that routes read data back to whoever issued the read.
module s_mem_arbiter
    import s_mem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    s_mem_arbiter_if.slave    bus,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_wren_o,
    input  logic [DATA_W-1:0] mem_q_i
);

    arb_state_t state_q, state_d;
    req_idx_t   owner_q, owner_d;
    req_idx_t   ptr_q,   ptr_d;
    req_vec_t   gnt_q,   gnt_d;

    logic       pick_any;
    req_vec_t   pick_onehot;
    req_idx_t   pick_idx;

    logic       owner_active;
    logic       rd_push;
    rd_tag_t    tag_q [RD_LAT];

    s_mem_arbiter_rr_pick u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .any_o    (pick_any),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    // Grant FSM: an owner keeps the RAM until it drops req; handover is immediate.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_GRANT;
                    owner_d = pick_idx;
                    gnt_d   = pick_onehot;
                    ptr_d   = next_idx(pick_idx);
                end
            end
            ARB_GRANT: begin
                if (!bus.req[owner_q]) begin
                    if (pick_any) begin
                        owner_d = pick_idx;
                        gnt_d   = pick_onehot;
                        ptr_d   = next_idx(pick_idx);
                    end else begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours regardless of block order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    assign owner_active = gnt_q[owner_q];
    assign rd_push      = owner_active & bus.req_rden[owner_q];

    always_comb begin
        mem_address_o = '0;
        mem_data_o    = '0;
        mem_wren_o    = 1'b0;
        if (owner_active) begin
            mem_address_o = bus.req_addr [int'(owner_q)*ADDR_W +: ADDR_W];
            mem_data_o    = bus.req_wdata[int'(owner_q)*DATA_W +: DATA_W];
            // A reset cycle must never corrupt the S table, even mid-burst.
            mem_wren_o    = bus.req_wren[owner_q] & ~rst_i;
        end
    end

    // Tags ride alongside the RAM latency so returns survive a grant handover.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: rd_push, idx: owner_q};
            for (int i = 1; i < RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.rdata  = mem_q_i;
    assign bus.rvalid = (tag_q[RD_LAT-1].valid && !rst_i) ? idx_to_onehot(tag_q[RD_LAT-1].idx) : '0;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Directed bench for s_mem_arbiter with a behavioural 256x8 RAM (read latency 1,
// read-old-data on a same-cycle write).
module tb_s_mem_arbiter;
    import s_mem_pkg::*;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;
    logic [7:0]        ram [256];

    int n_checks = 0;
    int n_fail   = 0;

    s_mem_arbiter_if bus ();

    s_mem_arbiter #(.RD_LAT(1)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bus           (bus),
        .mem_address_o (mem_address),
        .mem_data_o    (mem_data),
        .mem_wren_o    (mem_wren),
        .mem_q_i       (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        mem_q <= ram[mem_address];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_ch(input int i, input logic [7:0] a, input logic [7:0] d,
                          input logic we, input logic re);
        bus.req_addr[i*ADDR_W +: ADDR_W]  = a;
        bus.req_wdata[i*DATA_W +: DATA_W] = d;
        bus.req_wren[i] = we;
        bus.req_rden[i] = re;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.req       = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wren  = '0;
        bus.req_rden  = '0;
        mem_q         = '0;
        tick();
        tick();
        settle();
        check("rst_gnt",      32'(bus.gnt),    32'h0);
        check("rst_rvalid",   32'(bus.rvalid), 32'h0);
        check("rst_wren",     32'(mem_wren),   32'h0);
        check("rst_address",  32'(mem_address), 32'h0);
        check("rst_data",     32'(mem_data),   32'h0);

        // 1. initializer fills RAM[k] = k
        rst = 1'b0;
        bus.req = 3'b001;
        settle();
        check("t1_gnt_t0", 32'(bus.gnt), 32'h0);
        tick();
        check("t1_gnt_t1", 32'(bus.gnt), 32'h1);
        for (int k = 0; k < 256; k++) begin
            set_ch(0, 8'(k), 8'(k), 1'b1, 1'b0);
            settle();
            check("t1_write", {15'h0, mem_wren, mem_address, mem_data}, {15'h0, 1'b1, 8'(k), 8'(k)});
            tick();
        end
        set_ch(0, 8'h00, 8'h00, 1'b0, 1'b0);
        bus.req = 3'b000;
        tick();
        check("t1_release", 32'(bus.gnt), 32'h0);
        check("t1_ram0",   32'(ram[0]),   32'h00);
        check("t1_ram77",  32'(ram[77]),  32'h4d);
        check("t1_ram255", 32'(ram[255]), 32'hff);

        // 2. round-robin from ptr=0, then burst lock
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 3'b110;
        tick();
        check("t2_first", 32'(bus.gnt), 32'h2);
        bus.req = 3'b100;
        tick();
        check("t2_handover", 32'(bus.gnt), 32'h4);
        bus.req = 3'b110;
        tick();
        check("t2_lock_a", 32'(bus.gnt), 32'h4);
        tick();
        check("t2_lock_b", 32'(bus.gnt), 32'h4);

        // 3. owner 2 back-to-back reads of 5, 6, 7
        set_ch(2, 8'd5, 8'h00, 1'b0, 1'b1);
        settle();
        check("t3_rvalid_pre", 32'(bus.rvalid), 32'h0);
        tick();
        set_ch(2, 8'd6, 8'h00, 1'b0, 1'b1);
        settle();
        check("t3_rd5", {bus.rvalid, bus.rdata}, {3'b100, 8'd5});
        tick();
        set_ch(2, 8'd7, 8'h00, 1'b0, 1'b1);
        settle();
        check("t3_rd6", {bus.rvalid, bus.rdata}, {3'b100, 8'd6});
        tick();
        set_ch(2, 8'd0, 8'h00, 1'b0, 1'b0);
        settle();
        check("t3_rd7", {bus.rvalid, bus.rdata}, {3'b100, 8'd7});
        tick();
        check("t3_rvalid_post", 32'(bus.rvalid), 32'h0);

        // hand to requester 1 (ptr=0 after granting 2), then queue requester 0
        bus.req = 3'b010;
        tick();
        check("t4_gnt1", 32'(bus.gnt), 32'h2);
        bus.req = 3'b011;

        // 5. requester 2 strobes a write without the grant
        set_ch(2, 8'd3, 8'hAA, 1'b1, 1'b0);
        settle();
        check("t5_wren_blocked", 32'(mem_wren), 32'h0);
        check("t5_addr_owner1",  32'(mem_address), 32'h0);
        tick();
        set_ch(2, 8'd0, 8'h00, 1'b0, 1'b0);

        // 4. owner 1 reads 9 and releases in the same cycle
        set_ch(1, 8'd9, 8'h00, 1'b0, 1'b1);
        bus.req = 3'b001;
        settle();
        check("t4_addr9", 32'(mem_address), 32'h9);
        tick();
        set_ch(1, 8'd0, 8'h00, 1'b0, 1'b0);
        settle();
        check("t4_gnt0", 32'(bus.gnt), 32'h1);
        check("t4_rd9",  {bus.rvalid, bus.rdata}, {3'b010, 8'd9});
        tick();
        check("t4_rvalid_post", 32'(bus.rvalid), 32'h0);

        // RAM[3] must still hold 3 after the ignored write
        set_ch(0, 8'd3, 8'h00, 1'b0, 1'b1);
        tick();
        set_ch(0, 8'd0, 8'h00, 1'b0, 1'b0);
        settle();
        check("t5_rd3", {bus.rvalid, bus.rdata}, {3'b001, 8'd3});
        check("t5_ram3", 32'(ram[3]), 32'h03);

        // 6. reset during an owner-1 burst with a read in flight
        bus.req = 3'b010;
        tick();
        check("t6_gnt1", 32'(bus.gnt), 32'h2);
        set_ch(1, 8'd4, 8'h00, 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        set_ch(1, 8'd4, 8'h55, 1'b1, 1'b0);
        settle();
        check("t6_wren_in_rst",   32'(mem_wren),   32'h0);
        check("t6_rvalid_in_rst", 32'(bus.rvalid), 32'h0);
        tick();
        rst = 1'b0;
        set_ch(1, 8'd0, 8'h00, 1'b0, 1'b0);
        bus.req = 3'b111;
        settle();
        check("t6_gnt_after_rst",    32'(bus.gnt),    32'h0);
        check("t6_rvalid_after_rst", 32'(bus.rvalid), 32'h0);
        tick();
        check("t6_ptr_zero", 32'(bus.gnt), 32'h1);
        check("t6_ram4", 32'(ram[4]), 32'h04);
        bus.req = 3'b000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
